seq_muldiv: RTL and testbench

Multi-cycle, sign-magnitude signed divide/multiply engine with a valid/ready request port and a valid/ready response port. It shares the ALU's operation encoding, magnitude arithmetic, sign rule and flag semantics. It serves as the sequential responder for an issuing stage, iterating one bit per clock instead of evaluating combinationally, and returns quotient/product plus an updated flags word to writeback.

---
 rtl/seq_muldiv.sv | 195 +++++++++++++++++++
 tb/tb_seq_muldiv.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv.sv
// seq_muldiv: sequential sign-magnitude multiply/divide engine.
// Handles one request at a time. Multiply uses shift-add and divide uses
// restoring division, one bit per clock. It returns the signed result and
// the updated flags word over a valid/ready response port.
//
// Handshake rules (both ports): a transfer happens on a rising Clock edge
// where valid and ready are both high. The producer holds its payload stable
// while valid is high and ready is low. Ready does not depend on valid.
// InReady is high only in IDLE and only while ResetN is high.
// OutValid is high only in DONE.
module seq_muldiv #(
  parameter int l = 16
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         InValid,
  output logic         InReady,
  input  logic         Operation,
  input  logic [l-1:0] A,
  input  logic [l-1:0] B,
  input  logic [l-1:0] FlagsIn,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [l-1:0] R,
  output logic [l-1:0] FlagsOut,
  output logic [1:0]   DebugState
);

  localparam int lv = l - 1;
  localparam int cw = $clog2(l);

  // Flag bit positions within the flags word
  localparam int DivisionHasRemainderIdx   = 0;
  localparam int DivisionByZeroIdx         = 1;
  localparam int MultiplicationOverflowIdx = 2;

  localparam logic [cw-1:0] LastCount = cw'(lv);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, stateNext;

  // Operation context captured when a request is accepted
  logic          opMul;
  logic          sign;
  logic [lv:0]   operand;   // divisor magnitude (divide) or multiplicand magnitude (multiply)
  logic [lv:0]   flagsCap;
  logic [cw-1:0] count;

  // Shared 2l-bit working register.
  // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}
  // Multiply: {running product high half, product low bits / multiplier bits shifting out}
  logic [2*l-1:0] acc;

  logic        accept;
  logic [lv:0] absA, absB;
  logic        divByZero;
  logic [lv:0] dbzFlags;

  logic [l:0]     shifted, diff, sum;
  logic           qBit;
  logic [2*l-1:0] accStep;

  logic [lv:0] mag, rem, resSigned, flagsDone;
  logic        hasRem, ovf;

  assign InReady    = ResetN && (state == IDLE);
  assign OutValid   = (state == DONE);
  assign DebugState = state;
  assign accept     = InValid && InReady;

  // Magnitudes of the request operands; the most negative value maps onto itself
  always_comb begin
    absA      = A[lv] ? (~A + 1'b1) : A;
    absB      = B[lv] ? (~B + 1'b1) : B;
    divByZero = !Operation && (absB == '0);
    dbzFlags  = FlagsIn;
    dbzFlags[DivisionByZeroIdx]       = 1'b1;
    dbzFlags[DivisionHasRemainderIdx] = 1'b0;
  end

  // Next state: a zero-divisor divide skips the iteration phase
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = divByZero ? DONE : RUN;
        end
      end
      RUN: begin
        if (count == LastCount) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (OutReady) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // One iteration step: a restoring-divide bit or a shift-add multiply bit
  always_comb begin
    shifted = {acc[2*l-1:l], acc[lv]};
    diff    = shifted - {1'b0, operand};
    qBit    = ~diff[l];
    sum     = {1'b0, acc[2*l-1:l]} + (acc[0] ? {1'b0, operand} : '0);
    accStep = acc;
    if (opMul) begin
      accStep = {sum, acc[lv:1]};
    end else begin
      accStep = {(qBit ? diff[lv:0] : shifted[lv:0]), acc[l-2:0], qBit};
    end
  end

  // Result and flags produced from the final step, applied on the last RUN edge
  always_comb begin
    mag       = accStep[lv:0];
    rem       = accStep[2*l-1:l];
    hasRem    = |rem;
    ovf       = |accStep[2*l-1:lv];
    resSigned = sign ? (~mag + 1'b1) : mag;
    flagsDone = flagsCap;
    if (opMul) begin
      flagsDone[MultiplicationOverflowIdx] = ovf;
    end else begin
      flagsDone[DivisionHasRemainderIdx] = hasRem;
      flagsDone[DivisionByZeroIdx]       = 1'b0;
    end
  end

  // State register
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Capture, iteration and result registers
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      count    <= '0;
      R        <= '0;
      FlagsOut <= '0;
      opMul    <= 1'b0;
      sign     <= 1'b0;
      operand  <= '0;
      flagsCap <= '0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opMul    <= Operation;
            sign     <= A[lv] ^ B[lv];
            flagsCap <= FlagsIn;
            count    <= '0;
            if (Operation) begin
              operand <= absA;
              acc     <= {{l{1'b0}}, absB};
            end else begin
              operand <= absB;
              acc     <= {{l{1'b0}}, absA};
            end
            if (divByZero) begin
              R        <= '0;
              FlagsOut <= dbzFlags;
            end
          end
        end
        RUN: begin
          acc   <= accStep;
          count <= count + 1'b1;
          if (count == LastCount) begin
            R        <= resSigned;
            FlagsOut <= flagsDone;
          end
        end
        default: begin
          // DONE holds R and FlagsOut until the response handshake
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: randomized and directed checks of seq_muldiv against an
// arithmetic reference model of signed multiply/divide with flag update rules.
module tb_seq_muldiv;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        InValid;
  logic        InReady;
  logic        Operation;
  logic [15:0] A, B, FlagsIn;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] R, FlagsOut;
  logic [1:0]  DebugState;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected {R, FlagsOut} per accepted request
  logic [31:0] exp_q[$];

  seq_muldiv #(.l(16)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .InValid(InValid), .InReady(InReady),
    .Operation(Operation), .A(A), .B(B), .FlagsIn(FlagsIn),
    .OutValid(OutValid), .OutReady(OutReady),
    .R(R), .FlagsOut(FlagsOut), .DebugState(DebugState)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_model(input logic op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] f);
    int ma, mb, mag;
    logic neg;
    logic [15:0] r, fl;
    ma  = a[15] ? 65536 - int'(a) : int'(a);
    mb  = b[15] ? 65536 - int'(b) : int'(b);
    neg = a[15] ^ b[15];
    if (!op) begin
      if (mb == 0) return {16'h0000, f[15:2], 2'b10};
      mag = ma / mb;
      fl  = {f[15:2], 1'b0, (ma % mb) != 0};
    end else begin
      mag = ma * mb;
      fl  = {f[15:3], mag >= 32768, f[1:0]};
    end
    r = 16'(mag);
    if (neg) r = -r;
    return {r, fl};
  endfunction

  function automatic int exp_latency(input logic op, input logic [15:0] b);
    return (!op && b == 16'h0000) ? 1 : 17;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a request, waits for acceptance, then scrambles the inputs
  task automatic send_req(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] f);
    int waitc = 0;
    @(negedge Clock);
    Operation = op; A = a; B = b; FlagsIn = f; InValid = 1'b1;
    while (!InReady && waitc < 200) begin
      @(negedge Clock);
      waitc++;
    end
    check("accept_ready", InReady, 1);
    @(posedge Clock);
    #1;
    InValid   = 1'b0;
    Operation = 1'($urandom);
    A         = 16'($urandom);
    B         = 16'($urandom);
    FlagsIn   = 16'($urandom);
    exp_q.push_back(ref_model(op, a, b, f));
  endtask

  // Called just after the accept edge; counts edges (accept edge = 1) until OutValid
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge Clock);
    while (!OutValid && lat < 100) begin
      @(negedge Clock);
      lat++;
    end
    check("valid_seen", OutValid, 1);
  endtask

  // Waits for the response, checks it, optionally stalls, then handshakes
  task automatic collect(input string tag, input int exp_lat, input int hold, input bit early);
    int lat;
    logic [31:0] exp;
    if (early) OutReady = 1'b1;
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat);
    exp = exp_q.pop_front();
    check({tag, "_res"}, {R, FlagsOut}, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      check({tag, "_hold"}, {OutValid, InReady, R, FlagsOut}, {1'b1, 1'b0, exp});
    end
    OutReady = 1'b1;
    @(posedge Clock);
    #1;
    OutReady = 1'b0;
    @(negedge Clock);
    check({tag, "_rdy_after"}, {InReady, OutValid}, {1'b1, 1'b0});
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        op;
    logic [15:0] a, b, f, r, fo;
  } dir_t;

  dir_t dirs[9];

  initial begin
    int lat;
    bit saw_valid;
    logic [31:0] exp;
    logic        op;
    logic [15:0] a, b, f;

    dirs[0] = '{1'b0, 16'd7,    16'd2,    16'hFFF8, 16'h0003, 16'hFFF9};
    dirs[1] = '{1'b0, 16'hFFF9, 16'd2,    16'h0000, 16'hFFFD, 16'h0001};
    dirs[2] = '{1'b0, 16'hFFF8, 16'hFFFE, 16'h0000, 16'h0004, 16'h0000};
    dirs[3] = '{1'b0, 16'd5,    16'd0,    16'h0004, 16'h0000, 16'h0006};
    dirs[4] = '{1'b1, 16'd300,  16'd200,  16'h0003, 16'hEA60, 16'h0007};
    dirs[5] = '{1'b1, 16'hFFFD, 16'd4,    16'h0002, 16'hFFF4, 16'h0002};
    dirs[6] = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
    dirs[7] = '{1'b1, 16'h8000, 16'd1,    16'h0000, 16'h8000, 16'h0004};
    dirs[8] = '{1'b1, 16'd0,    16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFB};

    ResetN = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Operation = 1'b0; A = '0; B = '0; FlagsIn = '0;

    // Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_inready", InReady, 0);
    check("rst_outs", {OutValid, R, FlagsOut}, 33'h0);
    check("rst_state", DebugState, 2'd0);
    ResetN = 1'b1;
    #1;
    check("rst_release_ready", InReady, 1);

    // Directed cases with literal expectations
    for (int i = 0; i < 9; i++) begin
      send_req(dirs[i].op, dirs[i].a, dirs[i].b, dirs[i].f);
      exp = exp_q.pop_front();
      exp_q.push_front({dirs[i].r, dirs[i].fo});
      check($sformatf("dir%0d_model", i), exp, {dirs[i].r, dirs[i].fo});
      collect($sformatf("dir%0d", i), exp_latency(dirs[i].op, dirs[i].b), 0, 1'b0);
    end

    // Back-pressure with a second request held valid through RUN and DONE
    send_req(1'b0, 16'd1000, 16'd7, 16'h1230);
    Operation = 1'b1; A = 16'd123; B = 16'hFFD3; FlagsIn = 16'h00F0; InValid = 1'b1;
    wait_valid(lat);
    check("bp_lat", lat, 17);
    exp = exp_q.pop_front();
    check("bp_res", {R, FlagsOut}, exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("bp_hold", {OutValid, InReady, R, FlagsOut}, {1'b1, 1'b0, exp});
    end
    OutReady = 1'b1;
    @(posedge Clock);
    #1;
    OutReady = 1'b0;
    @(negedge Clock);
    check("bp_ready_after", {InReady, OutValid}, {1'b1, 1'b0});
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    exp_q.push_back(ref_model(1'b1, 16'd123, 16'hFFD3, 16'h00F0));
    collect("bp_second", 17, 0, 1'b0);

    // Reset during RUN aborts the operation silently
    send_req(1'b0, 16'd7, 16'd2, 16'h0000);
    void'(exp_q.pop_back());
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check("abort_inready_low", InReady, 0);
    @(negedge Clock);
    check("abort_rst_outs", {InReady, OutValid, R, FlagsOut}, 34'h0);
    ResetN = 1'b1;
    #1;
    check("abort_ready_back", InReady, 1);
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clock);
      saw_valid |= OutValid;
    end
    check("abort_no_valid", saw_valid, 0);
    send_req(1'b0, 16'd7, 16'd2, 16'h0000);
    collect("abort_fresh", 17, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int hold;
      bit early;
      op = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1, 2:    b = 16'($urandom_range(1, 15));
        3:       b = 16'hFFFF - 16'($urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) a = 16'h8000;
      f     = 16'($urandom);
      hold  = $urandom_range(0, 3);
      early = (hold == 0) && ($urandom_range(0, 1) == 1);
      send_req(op, a, b, f);
      collect($sformatf("rnd%0d", n), exp_latency(op, b), hold, early);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
